// File: rtl/long_div_pipe.sv
// Bit-serial (num_in * 2^len) mod modulus, used to move operands into the Montgomery R-domain.
// Optional quotient output ld_quot is enabled by defining LONG_DIV_QUOT_EN.
module long_div_pipe #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] num_in,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             md_end,
  output logic             md_err,
  output logic [WIDTH-1:0] ld_out
`ifdef LONG_DIV_QUOT_EN
  ,
  output logic [WIDTH-1:0] ld_quot
`endif
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, REDUCE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] num_r;
  logic [WIDTH-1:0] mod_r;
  logic [LEN_W-1:0] len_r;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] r;

  logic [WIDTH:0]   t_red;
  logic [WIDTH:0]   t_shf;
  logic [WIDTH-1:0] r_red;
  logic [WIDTH-1:0] r_shf;

  // t is one bit wider than r so 2r or {r,bit} never overflows before the compare
  function automatic logic mod_ge(input logic [WIDTH:0] t, input logic [WIDTH-1:0] m);
    return t >= {1'b0, m};
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH:0] t, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = t - {1'b0, m};
    return mod_ge(t, m) ? d[WIDTH-1:0] : t[WIDTH-1:0];
  endfunction

  assign t_red = {r, num_r[WIDTH-1]};
  assign t_shf = {r, 1'b0};
  assign r_red = mod_sub(t_red, mod_r);
  assign r_shf = mod_sub(t_shf, mod_r);

`ifdef LONG_DIV_QUOT_EN
  logic [WIDTH-1:0] quot_r;
  logic             q_red;
  assign q_red = mod_ge(t_red, mod_r);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      md_end <= 1'b0;
      md_err <= 1'b0;
      ld_out <= '0;
      num_r  <= '0;
      mod_r  <= '0;
      len_r  <= '0;
      idx    <= '0;
      r      <= '0;
`ifdef LONG_DIV_QUOT_EN
      quot_r  <= '0;
      ld_quot <= '0;
`endif
    end else begin
      md_end <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            num_r  <= num_in;
            mod_r  <= modulus;
            len_r  <= len;
            md_err <= 1'b0;
            busy   <= 1'b1;
            r      <= '0;
            idx    <= IDX_MAX;
`ifdef LONG_DIV_QUOT_EN
            quot_r <= '0;
`endif
            state  <= (modulus == '0) ? DONE : REDUCE;
          end
        end
        // Input reduction: long division of num_in, MSB first
        REDUCE: begin
          r     <= r_red;
          num_r <= {num_r[WIDTH-2:0], 1'b0};
          idx   <= idx - 1'b1;
`ifdef LONG_DIV_QUOT_EN
          quot_r <= {quot_r[WIDTH-2:0], q_red};
`endif
          if (idx == '0) begin
            if (len_r == '0) begin
              ld_out <= r_red;
              md_end <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
`ifdef LONG_DIV_QUOT_EN
              ld_quot <= {quot_r[WIDTH-2:0], q_red};
`endif
            end else begin
              state <= SHIFT;
            end
          end
        end
        // Doubling: one modular doubling per remaining len step
        SHIFT: begin
          r     <= r_shf;
          len_r <= len_r - 1'b1;
          if (len_r == LEN_W'(1)) begin
            ld_out <= r_shf;
            md_end <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
`ifdef LONG_DIV_QUOT_EN
            ld_quot <= quot_r;
`endif
          end
        end
        DONE: begin
          ld_out <= '0;
          md_end <= 1'b1;
          md_err <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
`ifdef LONG_DIV_QUOT_EN
          ld_quot <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/long_div_pipe.md
Name: long_div_pipe

Overview:
- Parametrised successor to the fixed 32-bit shift-modulo divider.
- Computes ld_out = (num_in * 2^len) mod modulus for any WIDTH. Arbitrary num_in is accepted, including num_in >= modulus.
- Runs bit-serially: an input-reduction phase, then a doubling phase.
- Sits in front of the Montgomery datapath and converts operands into the R-domain.
- Adds over its predecessor: busy status, divide-by-zero error reporting, and an optional quotient output.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- LEN_W, 8, width of len; at most 2^LEN_W-1 doubling steps.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- md_start  input  1  start request; sampled only when busy=0
- len  input  LEN_W  log2(R); latched at start
- num_in  input  WIDTH  dividend; latched at start
- modulus  input  WIDTH  modulus; latched at start
- busy  output  1  high from the start-accept edge until the edge that raises md_end
- md_end  output  1  one-cycle completion pulse
- md_err  output  1  high with md_end when modulus==0; held until the next accepted start
- ld_out  output  WIDTH  result; registered, held until the next completion
- ld_quot  output  WIDTH  floor(num_in/modulus); present only with LONG_DIV_QUOT_EN

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy, md_end, md_err, ld_out, ld_quot, and internal registers all go to 0. Reset asserted mid-operation aborts the operation with no md_end. After release, the block is in IDLE.
- States: IDLE, REDUCE, SHIFT, DONE.
- IDLE:
  - md_start=1 at edge E0 latches num_in, modulus, len; clears md_err; busy->1.
  - If modulus==0: go to DONE; at edge E1, md_end=1, md_err=1, ld_out=0, ld_quot=0, busy=0.
  - Otherwise: go to REDUCE with r=0, bit index=WIDTH-1.
- REDUCE: one step per edge, WIDTH edges, num_in bits processed MSB first.
  - t = {r,bit}, computed at WIDTH+1 bits.
  - If t >= modulus: r = t - modulus and quotient bit = 1; else r = t and quotient bit = 0.
  - After WIDTH steps, r = num_in mod modulus.
- SHIFT: len steps, one per edge.
  - t = 2r, computed at WIDTH+1 bits (no overflow possible since r < modulus).
  - If t >= modulus: r = t - modulus, else r = t.
  - len==0 skips SHIFT entirely.
- Completion:
  - The final step's edge (edge E0+WIDTH+len) registers ld_out=r and pulses md_end for exactly one cycle.
  - The same edge drops busy to 0 and returns the state to IDLE.
  - md_start may be accepted on the edge after md_end (back-to-back).
- md_start while busy=1 is ignored; latched operands do not change.
- Input changes after the accepting edge have no effect.
- modulus==1 gives ld_out=0 (normal path, md_err=0).
- Throughput: one operation per WIDTH+len+1 cycles.

Optional Feature:
- Macro: LONG_DIV_QUOT_EN.
- Defined:
  - ld_quot port exists.
  - The REDUCE phase shifts quotient bits into a WIDTH-bit register.
  - ld_quot = floor(num_in/modulus), registered at the md_end edge and held until the next completion; 0 on md_err.
- Undefined: ld_quot port and quotient register are absent; all other behaviour is identical.

Test Plan (WIDTH=32, LEN_W=8):
- num_in=10, modulus=11, len=4 -> md_end exactly 36 cycles after the start edge; ld_out=6; md_err=0; busy high for 36 cycles.
- num_in=1000, modulus=7, len=0 -> ld_out=6 after 32 cycles; ld_quot=142 (QUOT_EN); the SHIFT state is never visited.
- num_in=0xFFFFFFFF, modulus=0xFFFFFFFB, len=8 -> ld_out=1024 (no WIDTH+1 overflow); ld_quot=1.
- num_in=10, modulus=0, len=0 -> md_end and md_err one cycle after start; ld_out=0; next valid start clears md_err.
- Start num_in=25, modulus=13, len=4; pulse md_start again at cycle 10 with different operands -> second pulse ignored; ld_out=10.
- Start num_in=14, modulus=15, len=4; assert rst at cycle 20 -> outputs 0 immediately, no md_end. Restart after release -> ld_out=14 after 36 cycles.
